// File: rtl/ro_puf_response_gen.sv
// rtl/ro_puf_response_gen.sv - RO-PUF response sequencer; optional margin flags via RO_PUF_MARGIN_EN
module ro_puf_response_gen #(
    parameter int SEL_W      = 4,
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int RESP_BITS  = 8,
    parameter int SETTLE_CYC = 4,
    parameter int MARGIN     = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [SEL_W-1:0]     challenge,
    input  logic [WIN_W-1:0]     window,
    input  logic                 ro_a,
    input  logic                 ro_b,
    output logic [SEL_W-1:0]     sel_a,
    output logic [SEL_W-1:0]     sel_b,
    output logic                 busy,
    output logic                 done,
    output logic [RESP_BITS-1:0] resp,
    output logic                 resp_valid,
    output logic [RESP_BITS-1:0] unstable
);

    localparam int K_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam logic [K_W-1:0]   K_LAST      = K_W'(RESP_BITS - 1);
    localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_COUNT  = 3'd2,
        S_CMP    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                 state_q;
    logic [K_W-1:0]         k_q;
    logic [K_W-1:0]         k_d;
    logic [WIN_W-1:0]       tmr_q;
    logic [WIN_W-1:0]       win_q;
    logic [SEL_W-1:0]       chal_q;
    logic [SEL_W-1:0]       sel_a_q;
    logic [SEL_W-1:0]       sel_b_q;
    logic [SEL_W-1:0]       sel_a_d;
    logic [SEL_W-1:0]       sel_b_d;
    logic [CNT_W-1:0]       cnt_a_q;
    logic [CNT_W-1:0]       cnt_b_q;
    logic [RESP_BITS-1:0]   resp_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   rv_q;
    logic [2:0]             sync_a_q;
    logic [2:0]             sync_b_q;
    logic                   ev_a;
    logic                   ev_b;

    // Two synchronizer stages ([0],[1]) followed by the previous-value register ([2])
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync_a_q <= '0;
            sync_b_q <= '0;
        end else begin
            sync_a_q <= {sync_a_q[1:0], ro_a};
            sync_b_q <= {sync_b_q[1:0], ro_b};
        end
    end

    assign ev_a = sync_a_q[1] & ~sync_a_q[2];
    assign ev_b = sync_b_q[1] & ~sync_b_q[2];

    // Selects for the next pair: base + 2k and base + 2k + 1, wrapping over the bank
    always_comb begin
        k_d     = k_q + K_W'(1);
        sel_a_d = chal_q + SEL_W'({k_d, 1'b0});
        sel_b_d = sel_a_d + SEL_W'(1);
    end

`ifdef RO_PUF_MARGIN_EN
    localparam logic [CNT_W:0] MARGIN_V = (CNT_W + 1)'(MARGIN);
    logic [CNT_W:0]       diff_mag;
    logic [RESP_BITS-1:0] unstable_q;

    // Magnitude of the count difference, one bit wider so it never overflows
    always_comb begin
        diff_mag = '0;
        if (cnt_a_q >= cnt_b_q) diff_mag = {1'b0, cnt_a_q} - {1'b0, cnt_b_q};
        else                    diff_mag = {1'b0, cnt_b_q} - {1'b0, cnt_a_q};
    end

    assign unstable = unstable_q;
`else
    localparam int unused_margin = MARGIN;
    assign unstable = '0;
`endif

    // Measurement sequencer: settle, count a window, compare, repeat per response bit
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            tmr_q   <= '0;
            win_q   <= '0;
            chal_q  <= '0;
            sel_a_q <= '0;
            sel_b_q <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            resp_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rv_q    <= 1'b0;
`ifdef RO_PUF_MARGIN_EN
            unstable_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        chal_q  <= challenge;
                        win_q   <= (window == '0) ? WIN_W'(1) : window;
                        rv_q    <= 1'b0;
                        resp_q  <= '0;
                        k_q     <= '0;
                        tmr_q   <= '0;
                        sel_a_q <= challenge;
                        sel_b_q <= challenge + SEL_W'(1);
                        cnt_a_q <= '0;
                        cnt_b_q <= '0;
                        busy_q  <= 1'b1;
`ifdef RO_PUF_MARGIN_EN
                        unstable_q <= '0;
`endif
                        state_q <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    cnt_a_q <= '0;
                    cnt_b_q <= '0;
                    if (tmr_q == SETTLE_LAST) begin
                        tmr_q   <= '0;
                        state_q <= S_COUNT;
                    end else begin
                        tmr_q <= tmr_q + WIN_W'(1);
                    end
                end
                S_COUNT: begin
                    if (ev_a && (cnt_a_q != '1)) cnt_a_q <= cnt_a_q + CNT_W'(1);
                    if (ev_b && (cnt_b_q != '1)) cnt_b_q <= cnt_b_q + CNT_W'(1);
                    if (tmr_q == win_q - WIN_W'(1)) begin
                        tmr_q   <= '0;
                        state_q <= S_CMP;
                    end else begin
                        tmr_q <= tmr_q + WIN_W'(1);
                    end
                end
                S_CMP: begin
                    resp_q[k_q] <= (cnt_a_q > cnt_b_q);
`ifdef RO_PUF_MARGIN_EN
                    unstable_q[k_q] <= (diff_mag < MARGIN_V);
`endif
                    cnt_a_q <= '0;
                    cnt_b_q <= '0;
                    if (k_q == K_LAST) begin
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        k_q     <= k_d;
                        sel_a_q <= sel_a_d;
                        sel_b_q <= sel_b_d;
                        state_q <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b1;
                    rv_q    <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sel_a      = sel_a_q;
    assign sel_b      = sel_b_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign resp       = resp_q;
    assign resp_valid = rv_q;

endmodule

// File: tb/tb_ro_puf_response_gen.sv
// tb/tb_ro_puf_response_gen.sv - self-checking bench for ro_puf_response_gen with an oscillator-bank model
module tb_ro_puf_response_gen;

    localparam int SC = 4;
    localparam int RB = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  challenge = '0;
    logic [15:0] window = '0;
    logic        ro_a = 1'b0;
    logic        ro_b = 1'b0;
    logic [3:0]  sel_a;
    logic [3:0]  sel_b;
    logic        busy;
    logic        done;
    logic [7:0]  resp;
    logic        resp_valid;
    logic [7:0]  unstable;

    ro_puf_response_gen dut (
        .clk(clk), .rst_n(rst_n), .start(start), .challenge(challenge), .window(window),
        .ro_a(ro_a), .ro_b(ro_b), .sel_a(sel_a), .sel_b(sel_b), .busy(busy), .done(done),
        .resp(resp), .resp_valid(resp_valid), .unstable(unstable)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // oscillator bank: period 0 means constant level lvl
    int per[16];
    int ph[16];
    int lvl[16];

    function automatic logic oval(input int i, input int m);
        if (per[i] == 0) return (lvl[i] != 0);
        return (((m + ph[i]) % per[i]) < (per[i] / 2));
    endfunction

    // bank mux outside the DUT; value set here is sampled at edge number cyc
    always @(posedge clk) begin
        #2;
        ro_a = oval(int'(sel_a), cyc);
        ro_b = oval(int'(sel_b), cyc);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // model state
    int        m_T = -1;
    int        m_W = 1;
    int        m_ch = 0;
    bit        m_rst = 1'b0;
    bit        chk_en = 1'b0;
    logic [7:0] m_resp = '0;
    logic [7:0] m_unst = '0;

    // rising edges seen by the sampled oscillator that land inside a window starting at edge e0
    function automatic int mcount(input int osc, input int e0, input int w);
        int n;
        n = 0;
        for (int m = e0 - 1; m <= e0 + w - 2; m++)
            if (oval(osc, m) && !oval(osc, m - 1)) n++;
        if (n > 65535) n = 65535;
        return n;
    endfunction

    task automatic model_run(input int t, input int ch, input int win);
        int p, e0, a, b, ca, cb, d;
        m_W = (win == 0) ? 1 : win;
        p = SC + m_W + 1;
        for (int k = 0; k < RB; k++) begin
            e0 = t + k * p + SC;
            a  = (ch + 2 * k) % 16;
            b  = (ch + 2 * k + 1) % 16;
            ca = mcount(a, e0, m_W);
            cb = mcount(b, e0, m_W);
            d  = (ca > cb) ? ca - cb : cb - ca;
            m_resp[k] = (ca > cb);
            m_unst[k] = (d < 4);
        end
        m_ch = ch;
        m_T  = t;
    endtask

    // per-cycle comparison against the model
    always @(negedge clk) begin
        int x, p, n, kk;
        logic eb, ed, ev;
        logic [3:0] esa, esb;
        if (chk_en) begin
            x = cyc - 1;
            if (m_rst || m_T < 0) begin
                eb = 0; ed = 0; ev = 0; esa = '0; esb = '0;
                chk("resp_idle", 32'(resp), 32'd0);
                chk("unst_idle", 32'(unstable), 32'd0);
            end else begin
                p  = SC + m_W + 1;
                n  = RB * p;
                eb = (x >= m_T) && (x < m_T + n);
                ed = (x == m_T + n + 1);
                ev = (x >= m_T + n + 1);
                kk = (x - m_T) / p;
                if (kk > RB - 1) kk = RB - 1;
                esa = 4'(m_ch + 2 * kk);
                esb = 4'(m_ch + 2 * kk + 1);
                if (ev) chk("resp", 32'(resp), 32'(m_resp));
`ifdef RO_PUF_MARGIN_EN
                if (ev) chk("unstable", 32'(unstable), 32'(m_unst));
`else
                chk("unstable_tied", 32'(unstable), 32'd0);
`endif
            end
            chk("busy", 32'(busy), 32'(eb));
            chk("done", 32'(done), 32'(ed));
            chk("resp_valid", 32'(resp_valid), 32'(ev));
            chk("sel_a", 32'(sel_a), 32'(esa));
            chk("sel_b", 32'(sel_b), 32'(esb));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_bank(input int pe, input int po);
        for (int i = 0; i < 16; i++) begin
            per[i] = (i % 2 == 0) ? pe : po;
            ph[i]  = 0;
            lvl[i] = 0;
        end
    endtask

    task automatic do_start(input int ch, input int win, output int t);
        challenge = 4'(ch);
        window    = 16'(win);
        start     = 1'b1;
        tick();
        start = 1'b0;
        t = cyc - 1;
        model_run(t, ch, win);
    endtask

    task automatic wait_done(input int t, output int lat);
        lat = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = cyc - 1 - t;
                break;
            end
        end
        chk("done_seen", 32'(lat >= 0), 32'd1);
    endtask

    task automatic wait_cycle(input int target);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (cyc - 1 >= target) break;
        end
    endtask

    logic [3:0] exp_sel [8] = '{4'hE, 4'h0, 4'h2, 4'h4, 4'h6, 4'h8, 4'hA, 4'hC};
    logic [3:0] obs_a   [8];
    logic [3:0] obs_b   [8];

    initial begin
        int t, lat, n;
        // reset
        set_bank(4, 8);
        tick(); tick(); tick();
        m_rst  = 1'b1;
        chk_en = 1'b1;
        tick();
        rst_n = 1'b0;
        m_rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_rv", 32'(resp_valid), 0);
        chk("rst_resp", 32'(resp), 0);
        chk("rst_sel_a", 32'(sel_a), 0);
        chk("rst_sel_b", 32'(sel_b), 0);
        tick();

        // A faster than B, window 64
        set_bank(4, 8);
        do_start(0, 64, t);
        n = mcount(0, t + SC, 64);
        chk("model_cnt_a16", 32'(n >= 15 && n <= 17), 1);
        n = mcount(1, t + SC, 64);
        chk("model_cnt_b8", 32'(n >= 7 && n <= 9), 1);
        wait_done(t, lat);
        chk("lat_553", 32'(lat), 32'd553);
        chk("resp_ff", 32'(resp), 32'hFF);
`ifdef RO_PUF_MARGIN_EN
        chk("unst_00_wide", 32'(unstable), 32'h00);
`endif
        tick();

        // rates swapped
        set_bank(8, 4);
        do_start(0, 64, t);
        wait_done(t, lat);
        chk("resp_00_swap", 32'(resp), 32'h00);
        tick();

        // same source on both inputs: tie
        set_bank(6, 6);
        do_start(5, 30, t);
        wait_done(t, lat);
        chk("resp_00_tie", 32'(resp), 32'h00);
`ifdef RO_PUF_MARGIN_EN
        chk("unst_ff_tie", 32'(unstable), 32'hFF);
`endif
        tick();

        // challenge wrap, start pulsed while busy
        for (int i = 0; i < 16; i++) begin
            per[i] = 2 + $urandom_range(0, 8);
            ph[i]  = $urandom_range(0, 15);
            lvl[i] = 0;
        end
        do_start(14, 10, t);
        for (int k = 0; k < RB; k++) begin
            wait_cycle(t + k * 15);
            obs_a[k] = sel_a;
            obs_b[k] = sel_b;
            if (k == 2) begin
                tick();
                challenge = 4'h3;
                window    = 16'd5;
                start     = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        wait_done(t, lat);
        chk("lat_busy_start", 32'(lat), 32'd121);
        for (int k = 0; k < RB; k++) begin
            chk("wrap_sel_a", 32'(obs_a[k]), 32'(exp_sel[k]));
            chk("wrap_sel_b", 32'(obs_b[k]), 32'(exp_sel[k] + 4'h1));
        end
        tick();

        // window 0 treated as 1; A held high
        set_bank(0, 2);
        for (int i = 0; i < 16; i += 2) lvl[i] = 1;
        do_start(0, 0, t);
        chk("model_cnt_a0", 32'(mcount(0, t + SC, 1)), 0);
        wait_done(t, lat);
        chk("lat_49", 32'(lat), 32'd49);
        chk("resp_00_w0", 32'(resp), 32'h00);
        tick();

        // reset in the middle of bit 3's count window
        set_bank(4, 8);
        do_start(0, 32, t);
        wait_cycle(t + 3 * 37 + SC + 10);
        tick();
        rst_n = 1'b1;
        m_rst = 1'b1;
        m_T   = -1;
        @(negedge clk);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_resp", 32'(resp), 0);
        chk("mid_rst_sel", 32'(sel_a), 0);
        tick();
        rst_n = 1'b0;
        m_rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        do_start(0, 64, t);
        wait_done(t, lat);
        chk("post_rst_lat", 32'(lat), 32'd553);
        chk("post_rst_resp", 32'(resp), 32'hFF);
        tick();

        // randomized runs
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 16; i++) begin
                per[i] = ($urandom_range(0, 7) == 0) ? 0 : 2 + $urandom_range(0, 10);
                ph[i]  = $urandom_range(0, 15);
                lvl[i] = $urandom_range(0, 1);
            end
            do_start($urandom_range(0, 15), $urandom_range(0, 40), t);
            wait_done(t, lat);
            chk("rand_lat", 32'(lat), 32'(RB * (SC + m_W + 1) + 1));
            tick();
            for (int i = 0; i < $urandom_range(0, 3); i++) tick();
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule

// File: doc/ro_puf_response_gen.md
Name: ro_puf_response_gen

Overview:
- Response-generation stage that sits directly downstream of the ring-oscillator bank and its select muxes.
- Drives the two oscillator selects, synchronizes the two selected oscillator outputs into the clk domain, and counts their rising edges over a programmable window.
- Compares each pair of counts and assembles an N-bit PUF response, with a start/busy/done handshake to the host logic.
- Replaces free-running, asynchronously clocked counters with a single-clock, deterministic measurement sequencer.

Parameters:
- SEL_W, 4: width of each oscillator select (2^SEL_W oscillators per bank).
- CNT_W, 16: edge-counter width.
- WIN_W, 16: width of the window-length input.
- RESP_BITS, 8: number of response bits per challenge.
- SETTLE_CYC, 4: clk cycles waited after a select change before counting.
- MARGIN, 4: minimum |cnt_a-cnt_b| for a stable bit (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-high.
- start  in  1  begin a response; sampled only in IDLE.
- challenge  in  SEL_W  base select value; latched on start acceptance.
- window  in  WIN_W  count window in clk cycles; latched on start acceptance.
- ro_a  in  1  selected oscillator A output (asynchronous to clk).
- ro_b  in  1  selected oscillator B output (asynchronous to clk).
- sel_a  out  SEL_W  oscillator A select to the bank mux.
- sel_b  out  SEL_W  oscillator B select to the bank mux.
- busy  out  1  high in SETTLE, COUNT and CMP.
- done  out  1  one-cycle pulse when the response is complete.
- resp  out  RESP_BITS  response; resp[k] is the result of pair k.
- resp_valid  out  1  resp is complete and stable.
- unstable  out  RESP_BITS  per-bit low-margin flags.

Behaviour:
- Reset (asynchronous, rst_n=1) forces:
  - FSM to IDLE.
  - sel_a, sel_b, resp, unstable, cnt_a, cnt_b, the bit index and the sync flops to 0.
  - busy, done and resp_valid to 0.
  - Reset asserted mid-operation aborts the response. No done pulse is issued and no partial resp is retained.
- Synchronizers: each of ro_a and ro_b passes through a 2-FF synchronizer plus an edge register. A count event is (sync=1 && prev=0).
- FSM states: IDLE, SETTLE, COUNT, CMP, DONE.
- IDLE:
  - On start=1, latch challenge and window, clear resp_valid, set k=0, go to SETTLE.
  - window=0 is latched as 1.
- SETTLE:
  - sel_a = challenge + 2k mod 2^SEL_W; sel_b = challenge + 2k + 1 mod 2^SEL_W.
  - cnt_a and cnt_b are held at 0.
  - Edge detection runs, but edges are discarded.
  - After SETTLE_CYC cycles, go to COUNT.
- COUNT:
  - Lasts exactly W latched cycles.
  - Each count event increments its counter.
  - Counters saturate at 2^CNT_W-1 and do not wrap.
  - Simultaneous A and B events both count.
  - Then go to CMP.
- CMP (1 cycle):
  - resp[k] <= (cnt_a > cnt_b). A tie gives 0.
  - If k == RESP_BITS-1, go to DONE. Otherwise k++, clear counters, go to SETTLE.
- DONE (1 cycle): done=1, resp_valid=1, then go to IDLE.
  - resp and resp_valid hold until the next accepted start or reset.
- start is ignored while busy or in DONE. No queuing.
- Timing: start accepted at edge T gives the done pulse in cycle T + RESP_BITS*(SETTLE_CYC+W+1) + 1.
- The synchronizer adds 2 cycles of latency. Edges in the last 2 cycles of a window are not counted; this applies equally to both oscillators.

Optional Feature:
- Macro: RO_PUF_MARGIN_EN.
- Defined:
  - In CMP, unstable[k] <= (|cnt_a-cnt_b| < MARGIN), computed on CNT_W+1-bit unsigned difference.
  - unstable is cleared on start acceptance and is valid with resp_valid.
- Undefined:
  - unstable is tied to 0 and no difference/magnitude logic is built.
  - All other behaviour is identical.

Test Plan:
- Reset mid-COUNT (k=3) -> all outputs 0 next cycle, FSM in IDLE, no done pulse; a following start runs normally.
- challenge=0, window=64, ro_a rises every 4 clk, ro_b rises every 8 clk -> cnt_a=16±1, cnt_b=8±1, resp=8'hFF, done at T+8*(4+64+1)+1 = T+553.
- Swap the oscillator rates -> resp=8'h00; ro_a=ro_b from the same source -> tie, resp=8'h00.
- challenge=4'hE -> pair selects observed in order: (E,F), (0,1), (2,3), ... (C,D), i.e. mod-16 wrap; start pulsed while busy is ignored and resp/done timing is unchanged.
- window=0 -> treated as 1 cycle per bit, done at T+8*6+1; ro_a held constant high during SETTLE -> cnt_a=0.
- RO_PUF_MARGIN_EN defined, counts 16 vs 14 -> resp bit=1, unstable bit=1; counts 16 vs 8 -> unstable bit=0; macro undefined -> unstable=0 always.
